// File: rtl/temp_c2f_stream.sv
// Purpose: streaming Celsius-to-Fahrenheit converter, F = floor(9*C/5) + 32, with an output FIFO.
// Latency: accept-to-FIFO push is WIDTH+6 edges; one sample in flight, one sample per WIDTH+7 cycles at best.
// Backpressure: in_ready stays low until the result is pushed, and the result waits in PUSH while the FIFO is full.
module temp_c2f_stream #(
    parameter int WIDTH = 8,
    parameter int DEPTH = 4
) (
    input  logic                     clk,
    input  logic                     rst_n,
    input  logic                     in_valid,
    output logic                     in_ready,
    input  logic [WIDTH-1:0]         in_data,
    output logic                     out_valid,
    input  logic                     out_ready,
    output logic [WIDTH+1:0]         out_data,
    output logic [$clog2(DEPTH):0]   level
);

    localparam int PW   = $clog2(DEPTH);   // FIFO pointer width
    localparam int LW   = PW + 1;          // level width, holds 0..DEPTH
    localparam int PWID = WIDTH + 4;       // product width, 9*C never overflows it
    localparam int CW   = $clog2(PWID + 1);
    localparam int OW   = WIDTH + 2;       // result width

    typedef enum logic [1:0] {
        S_IDLE,
        S_MUL,
        S_DIV,
        S_PUSH
    } state_t;

    state_t            state_q, state_d;
    logic [WIDTH-1:0]  t_q, t_d;
    logic [PWID-1:0]   p_q, p_d;
    logic [2:0]        rem_q, rem_d;
    // The quotient never exceeds WIDTH+1 significant bits, so the leading
    // bits shifted out of this narrower register are always zero.
    logic [OW-1:0]     quo_q, quo_d;
    logic [CW-1:0]     cnt_q, cnt_d;

    logic [OW-1:0]     mem_q [DEPTH];
    logic [PW-1:0]     wr_ptr_q, rd_ptr_q;
    logic [LW-1:0]     level_q;

    logic              push;
    logic              pop;
    logic [3:0]        rem_sh;
    logic              qbit;
    logic [OW-1:0]     result;

    assign result = quo_q + OW'(32);
    assign pop    = (level_q != '0) && out_ready;

    // FSM next state and datapath next values: latch, multiply, divide by 5, push.
    always_comb begin
        state_d  = state_q;
        t_d      = t_q;
        p_d      = p_q;
        rem_d    = rem_q;
        quo_d    = quo_q;
        cnt_d    = cnt_q;
        in_ready = 1'b0;
        push     = 1'b0;
        rem_sh   = '0;
        qbit     = 1'b0;
        case (state_q)
            S_IDLE: begin
                in_ready = 1'b1;
                if (in_valid) begin
                    t_d     = in_data;
                    state_d = S_MUL;
                end
            end
            S_MUL: begin
                p_d     = ({4'b0000, t_q} << 3) + {4'b0000, t_q};
                rem_d   = '0;
                quo_d   = '0;
                cnt_d   = CW'(PWID);
                state_d = S_DIV;
            end
            S_DIV: begin
                // Restoring step: remainder is always < 5 so 3 bits suffice;
                // the subtraction result also fits 3 bits (mod-8 arithmetic is exact here).
                rem_sh = {rem_q, p_q[PWID-1]};
                qbit   = (rem_sh >= 4'd5);
                rem_d  = qbit ? (rem_sh[2:0] - 3'd5) : rem_sh[2:0];
                quo_d  = {quo_q[OW-2:0], qbit};
                p_d    = p_q << 1;
                cnt_d  = cnt_q - CW'(1);
                if (cnt_q == CW'(1)) begin
                    state_d = S_PUSH;
                end
            end
            S_PUSH: begin
                // Full test on the registered level: a same-edge pop does not make room.
                if (level_q < LW'(DEPTH)) begin
                    push    = 1'b1;
                    state_d = S_IDLE;
                end
            end
            default: state_d = S_IDLE;
        endcase
    end

    // FSM and datapath registers.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= S_IDLE;
            t_q     <= '0;
            p_q     <= '0;
            rem_q   <= '0;
            quo_q   <= '0;
            cnt_q   <= '0;
        end else begin
            state_q <= state_d;
            t_q     <= t_d;
            p_q     <= p_d;
            rem_q   <= rem_d;
            quo_q   <= quo_d;
            cnt_q   <= cnt_d;
        end
    end

    // Output FIFO storage, pointers (wrap naturally, DEPTH is a power of two) and level.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            for (int i = 0; i < DEPTH; i++) begin
                mem_q[i] <= '0;
            end
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            level_q  <= '0;
        end else begin
            if (push) begin
                mem_q[wr_ptr_q] <= result;
                wr_ptr_q        <= wr_ptr_q + PW'(1);
            end
            if (pop) begin
                rd_ptr_q <= rd_ptr_q + PW'(1);
            end
            if (push && !pop) begin
                level_q <= level_q + LW'(1);
            end else if (pop && !push) begin
                level_q <= level_q - LW'(1);
            end
        end
    end

    assign out_valid = (level_q != '0);
    assign out_data  = (level_q != '0) ? mem_q[rd_ptr_q] : '0;
    assign level     = level_q;

endmodule

// File: tb/tb_temp_c2f_stream.sv
// Purpose: self-checking bench for temp_c2f_stream against an arithmetic reference model.
// Latency: checks the WIDTH+6 edge accept-to-output timing and one-per-WIDTH+7 throughput.
// Backpressure: exercises full-FIFO stall, push/pop at the same edge, and mid-conversion reset.
module tb_temp_c2f_stream;

    localparam int WIDTH = 8;
    localparam int DEPTH = 4;

    logic                   clk;
    logic                   rst_n;
    logic                   in_valid;
    logic                   in_ready;
    logic [WIDTH-1:0]       in_data;
    logic                   out_valid;
    logic                   out_ready;
    logic [WIDTH+1:0]       out_data;
    logic [$clog2(DEPTH):0] level;

    int n_checks = 0;
    int n_fail   = 0;
    int cyc      = 0;
    int n_acc    = 0;
    int exp_q[$];
    int got_q[$];
    int acc_cyc[$];

    temp_c2f_stream #(.WIDTH(WIDTH), .DEPTH(DEPTH)) dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .in_data   (in_data),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .out_data  (out_data),
        .level     (level)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Reference: plain integer arithmetic.
    function automatic int c2f(input int c);
        return (9 * c) / 5 + 32;
    endfunction

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_checks++;
        if (obs !== exp) begin
            n_fail++;
            $display("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic send(input logic [WIDTH-1:0] c);
        int n;
        n = 0;
        while (!in_ready && n < 100) begin
            step();
            n++;
        end
        if (!in_ready) chk("send_timeout", 0, 1);
        in_valid = 1'b1;
        in_data  = c;
        step();
        in_valid = 1'b0;
    endtask

    // Scoreboard: sampled on the falling edge, predicts what the next rising edge does.
    always @(negedge clk) begin
        cyc++;
        if (!rst_n) begin
            exp_q.delete();
        end else begin
            chk("ovld_vs_level", out_valid, level != 0);
            if (in_valid && in_ready) begin
                exp_q.push_back(c2f(int'(in_data)));
                acc_cyc.push_back(cyc);
                n_acc++;
            end
            if (out_valid && out_ready) begin
                got_q.push_back(int'(out_data));
                if (exp_q.size() == 0) chk("sb_unexpected", 1, 0);
                else chk("sb_data", out_data, exp_q.pop_front());
            end
        end
    end

    // Watchdog so the bench always ends.
    initial begin
        #2000000;
        $display("FAIL watchdog observed=timeout expected=finish");
        $fatal(1, "watchdog");
    end

    initial begin
        int basic_c[5];
        int basic_f[5];
        int b2b_c[5];
        int b2b_f[5];
        int bp_c[6];
        int idx;
        int n0;
        logic early;
        logic acc;

        basic_c = '{0, 1, 37, 100, 255};
        basic_f = '{32, 33, 98, 212, 491};
        b2b_c   = '{10, 20, 30, 40, 50};
        b2b_f   = '{50, 68, 86, 104, 122};
        bp_c    = '{11, 22, 33, 44, 55, 66};

        rst_n = 1'b0; in_valid = 1'b0; in_data = '0; out_ready = 1'b0;

        // Reset state
        repeat (3) step();
        chk("rst_in_ready", in_ready, 1);
        chk("rst_out_valid", out_valid, 0);
        chk("rst_out_data", out_data, 0);
        chk("rst_level", level, 0);
        rst_n = 1'b1;
        step();
        chk("rel_in_ready", in_ready, 1);

        // Basic values and 14-edge latency
        out_ready = 1'b1;
        for (int i = 0; i < 5; i++) begin
            send(WIDTH'(basic_c[i]));
            early = 1'b0;
            repeat (13) begin
                step();
                if (out_valid) early = 1'b1;
            end
            chk("lat_early", early, 0);
            step();
            chk("lat14_valid", out_valid, 1);
            chk("lat14_data", out_data, basic_f[i]);
            chk("rdy_after_push", in_ready, 1);
            step();
            chk("basic_drained", level, 0);
        end

        // Back-to-back with in_valid held high
        got_q.delete(); acc_cyc.delete();
        idx = 0; in_valid = 1'b1; in_data = WIDTH'(b2b_c[0]);
        for (int n = 0; n < 200 && idx < 5; n++) begin
            acc = in_ready;
            step();
            if (acc) begin
                idx++;
                if (idx < 5) in_data = WIDTH'(b2b_c[idx]);
                else in_valid = 1'b0;
            end
        end
        in_valid = 1'b0;
        repeat (20) step();
        chk("b2b_count", got_q.size(), 5);
        for (int i = 0; i < 5 && i < got_q.size(); i++) chk("b2b_data", got_q[i], b2b_f[i]);
        for (int i = 0; i < 4 && i + 1 < acc_cyc.size(); i++)
            chk("b2b_spacing", acc_cyc[i+1] - acc_cyc[i], 15);

        // Backpressure: six offered, FIFO fills at four, fifth stalls in PUSH
        out_ready = 1'b0; n0 = n_acc; idx = 0;
        in_valid = 1'b1; in_data = WIDTH'(bp_c[0]);
        repeat (90) begin
            acc = in_ready;
            step();
            if (acc && idx < 5) begin
                idx++;
                in_data = WIDTH'(bp_c[idx]);
            end
        end
        chk("bp_level_full", level, 4);
        chk("bp_out_valid", out_valid, 1);
        chk("bp_in_ready_low", in_ready, 0);
        chk("bp_accepted5", n_acc - n0, 5);
        out_ready = 1'b1;
        step();
        out_ready = 1'b0;
        chk("bp_after_pop", level, 3);
        step();
        chk("bp_refill", level, 4);
        chk("bp_ready_again", in_ready, 1);
        step();
        in_valid = 1'b0;
        chk("bp_accepted6", n_acc - n0, 6);
        out_ready = 1'b1;
        repeat (40) step();
        chk("bp_drain_level", level, 0);
        chk("bp_drain_sb", exp_q.size(), 0);

        // Simultaneous push and pop at level 2, across pointer wrap
        out_ready = 1'b0;
        send(WIDTH'($urandom_range(0, 255)));
        send(WIDTH'($urandom_range(0, 255)));
        for (int n = 0; n < 40 && level != 2; n++) step();
        chk("pp_start_level", level, 2);
        for (int i = 0; i < 10; i++) begin
            send(WIDTH'($urandom_range(0, 255)));
            repeat (13) step();
            out_ready = 1'b1;
            step();
            out_ready = 1'b0;
            chk("pp_level", level, 2);
        end
        out_ready = 1'b1;
        repeat (6) step();
        chk("pp_drain", level, 0);

        // Reset in the middle of a division, with one entry buffered
        out_ready = 1'b0;
        send(WIDTH'(77));
        repeat (15) step();
        chk("mr_level1", level, 1);
        send(WIDTH'(100));
        repeat (6) step();
        #2;
        rst_n = 1'b0;
        #1;
        chk("mr_in_ready", in_ready, 1);
        chk("mr_out_valid", out_valid, 0);
        chk("mr_level", level, 0);
        chk("mr_out_data", out_data, 0);
        got_q.delete();
        repeat (2) step();
        rst_n = 1'b1;
        chk("mr_rel_ready", in_ready, 1);
        out_ready = 1'b1;
        send(WIDTH'(0));
        repeat (20) step();
        chk("mr_count", got_q.size(), 1);
        if (got_q.size() > 0) chk("mr_data", got_q[0], 32);

        // Pop attempts on an empty FIFO
        out_ready = 1'b1;
        repeat (3) step();
        chk("empty_level", level, 0);
        chk("empty_data", out_data, 0);
        chk("empty_valid", out_valid, 0);
        out_ready = 1'b0;
        send(WIDTH'(5));
        send(WIDTH'(200));
        repeat (20) step();
        chk("empty_refill", level, 2);
        out_ready = 1'b1;
        repeat (4) step();
        chk("empty_drain", level, 0);

        // Randomized traffic against the model
        repeat (3000) begin
            in_valid  = ($urandom_range(0, 1) == 1);
            in_data   = WIDTH'($urandom_range(0, 255));
            out_ready = ($urandom_range(0, 3) != 0);
            step();
        end
        in_valid = 1'b0;
        out_ready = 1'b1;
        repeat (40) step();
        chk("rnd_sb_drained", exp_q.size(), 0);
        chk("rnd_level", level, 0);

        $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
        $finish;
    end

endmodule
